// File: rtl/dds_phase_accumulator.sv
// DDS phase generator: FTW accumulator with phase offset, load handshake,
// linear frequency sweep and a wrap pulse aligned with the phase output.
module dds_phase_accumulator #(
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned PHASE_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [ACC_WIDTH-1:0]   ftw_in,
  input  logic [PHASE_WIDTH-1:0] phase_off_in,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  input  logic                   sweep_start,
  input  logic [ACC_WIDTH-1:0]   sweep_step,
  input  logic [ACC_WIDTH-1:0]   sweep_stop,
  output logic                   sweep_done,
  output logic                   cycle_tick,
  output logic [PHASE_WIDTH-1:0] phase
);

  typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   ftw_q, ftw_d;
  logic [PHASE_WIDTH-1:0] poff_q, poff_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   wrap_q, wrap_d;
  logic                   tick_q;
  logic                   done_q, done_d;
  logic [ACC_WIDTH:0]     sum;
  logic [ACC_WIDTH:0]     nxt;
  logic                   load;

  always_comb begin
    load    = ftw_valid && (state_q != SWEEP);
    sum     = {1'b0, acc_q} + {1'b0, ftw_q};
    nxt     = {1'b0, ftw_q} + {1'b0, sweep_step};
    state_d = state_q;
    acc_d   = acc_q;
    ftw_d   = load ? ftw_in : ftw_q;
    poff_d  = load ? phase_off_in : poff_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
        end else begin
          acc_d  = sum[ACC_WIDTH-1:0];
          wrap_d = sum[ACC_WIDTH];
          if (sweep_start) state_d = SWEEP;
        end
      end
      SWEEP: begin
        // Abort wins over a coincident wrap: ftw keeps its value, no done pulse.
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
        end else begin
          acc_d  = sum[ACC_WIDTH-1:0];
          wrap_d = sum[ACC_WIDTH];
          if (sum[ACC_WIDTH]) begin
            if (nxt >= {1'b0, sweep_stop}) begin
              ftw_d   = sweep_stop;
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              ftw_d = nxt[ACC_WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    phase_d = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH] + poff_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ftw_q   <= '0;
      poff_q  <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ftw_q   <= ftw_d;
      poff_q  <= poff_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      // Second stage lines the carry up with the phase sample of the wrapped acc.
      tick_q  <= wrap_q;
      done_q  <= done_d;
    end
  end

  assign ftw_ready  = (state_q != SWEEP);
  assign sweep_done = done_q;
  assign cycle_tick = tick_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator: counting, offset wrap, load latency,
// sweep clamp/abort, load coincident with sweep start, async reset mid-sweep.
module tb_dds_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] ftw_in;
  logic [9:0]  phase_off_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic        sweep_start;
  logic [15:0] sweep_step;
  logic [15:0] sweep_stop;
  logic        sweep_done;
  logic        cycle_tick;
  logic [9:0]  phase;

  int vectors     = 0;
  int miscompares = 0;

  dds_phase_accumulator #(.ACC_WIDTH(16), .PHASE_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ftw_in(ftw_in),
    .phase_off_in(phase_off_in), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_stop(sweep_stop),
    .sweep_done(sweep_done), .cycle_tick(cycle_tick), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable       = 1'b0;
    ftw_in       = '0;
    phase_off_in = '0;
    ftw_valid    = 1'b0;
    sweep_start  = 1'b0;
    sweep_step   = '0;
    sweep_stop   = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      vectors++;
      if (phase !== 10'd0 || ftw_ready !== 1'b1 || sweep_done !== 1'b0 || cycle_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset n=%0d got phase=%0d ready=%b done=%b tick=%b expected 0/1/0/0",
                 n, phase, ftw_ready, sweep_done, cycle_tick);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_count(input int poff);
    int exp_phase;
    do_reset();
    ftw_in = 16'd64; phase_off_in = 10'(poff); ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 1030; n++) begin
      cyc();
      if (n == 1) ftw_valid = 1'b0;
      exp_phase = (n < 2) ? 0 : (n - 2 + poff) % 1024;
      vectors++;
      if (phase !== 10'(exp_phase)) begin
        miscompares++;
        $display("FAIL count_phase poff=%0d n=%0d got %0d expected %0d", poff, n, phase, exp_phase);
      end
      vectors++;
      if (cycle_tick !== (n == 1026)) begin
        miscompares++;
        $display("FAIL count_tick poff=%0d n=%0d got %b expected %b", poff, n, cycle_tick, n == 1026);
      end
    end
  endtask

  task automatic test_handshake();
    int exp_phase;
    do_reset();
    ftw_in = 16'd64; ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      ftw_valid = 1'b0;
      if (n == 9) begin ftw_in = 16'd128; ftw_valid = 1'b1; end
      exp_phase = (n < 2) ? 0 : (n <= 11) ? n - 2 : 9 + 2 * (n - 11);
      vectors++;
      if (phase !== 10'(exp_phase)) begin
        miscompares++;
        $display("FAIL handshake_phase n=%0d got %0d expected %0d", n, phase, exp_phase);
      end
      vectors++;
      if (ftw_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL handshake_ready n=%0d got %b expected 1", n, ftw_ready);
      end
    end
  endtask

  task automatic test_sweep_clamp();
    logic        exp_ready;
    logic [15:0] exp_ftw;
    do_reset();
    ftw_in = 16'd64; sweep_step = 16'd64; sweep_stop = 16'd200; ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 1885; n++) begin
      cyc();
      if (n == 1) begin ftw_valid = 1'b0; sweep_start = 1'b1; end
      if (n == 2) sweep_start = 1'b0;
      exp_ready = !(n >= 2 && n < 1879);
      vectors++;
      if (ftw_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL sweep_ready n=%0d got %b expected %b", n, ftw_ready, exp_ready);
      end
      vectors++;
      if (sweep_done !== (n == 1879)) begin
        miscompares++;
        $display("FAIL sweep_done n=%0d got %b expected %b", n, sweep_done, n == 1879);
      end
      if (n == 1024 || n == 1025 || n == 1536 || n == 1537 || n == 1878 || n == 1879 || n == 1885) begin
        exp_ftw = (n < 1025) ? 16'd64 : (n < 1537) ? 16'd128 : (n < 1879) ? 16'd192 : 16'd200;
        vectors++;
        if (dut.ftw_q !== exp_ftw) begin
          miscompares++;
          $display("FAIL sweep_ftw n=%0d got %0d expected %0d", n, dut.ftw_q, exp_ftw);
        end
      end
    end
  endtask

  task automatic test_sweep_abort();
    logic exp_ready;
    do_reset();
    ftw_in = 16'd64; phase_off_in = 10'd77; sweep_step = 16'd64; sweep_stop = 16'd200;
    ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 1032; n++) begin
      cyc();
      if (n == 1) begin ftw_valid = 1'b0; sweep_start = 1'b1; end
      if (n == 2) sweep_start = 1'b0;
      if (n == 1025) enable = 1'b0;
      exp_ready = !(n >= 2 && n < 1026);
      vectors++;
      if (ftw_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL abort_ready n=%0d got %b expected %b", n, ftw_ready, exp_ready);
      end
      vectors++;
      if (sweep_done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_done n=%0d got %b expected 0", n, sweep_done);
      end
      if (n >= 1025) begin
        vectors++;
        if (dut.ftw_q !== 16'd128) begin
          miscompares++;
          $display("FAIL abort_ftw n=%0d got %0d expected 128", n, dut.ftw_q);
        end
      end
      if (n >= 1027) begin
        vectors++;
        if (phase !== 10'd77) begin
          miscompares++;
          $display("FAIL abort_phase n=%0d got %0d expected 77", n, phase);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    do_reset();
    ftw_in = 16'd100; sweep_step = 16'd64; sweep_stop = 16'd200; ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 225; n++) begin
      cyc();
      if (n == 1) begin ftw_in = 16'd300; sweep_start = 1'b1; end
      if (n == 2) begin ftw_valid = 1'b0; sweep_start = 1'b0; end
      exp_ready = !(n >= 2 && n < 221);
      vectors++;
      if (ftw_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL b2b_ready n=%0d got %b expected %b", n, ftw_ready, exp_ready);
      end
      vectors++;
      if (sweep_done !== (n == 221)) begin
        miscompares++;
        $display("FAIL b2b_done n=%0d got %b expected %b", n, sweep_done, n == 221);
      end
      if (n == 3 || n == 221) begin
        vectors++;
        if (dut.ftw_q !== ((n == 3) ? 16'd300 : 16'd200)) begin
          miscompares++;
          $display("FAIL b2b_ftw n=%0d got %0d expected %0d", n, dut.ftw_q, (n == 3) ? 300 : 200);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ftw_in = 16'd64; sweep_step = 16'd64; sweep_stop = 16'd200; ftw_valid = 1'b1; enable = 1'b1;
    for (int n = 1; n <= 1100; n++) begin
      cyc();
      if (n == 1) begin ftw_valid = 1'b0; sweep_start = 1'b1; end
      if (n == 2) sweep_start = 1'b0;
    end
    vectors++;
    if (phase !== 10'd148 || ftw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_pre got phase=%0d ready=%b expected 148/0", phase, ftw_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (phase !== 10'd0 || ftw_ready !== 1'b1 || sweep_done !== 1'b0 || cycle_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got phase=%0d ready=%b done=%b tick=%b expected 0/1/0/0",
               phase, ftw_ready, sweep_done, cycle_tick);
    end
    vectors++;
    if (dut.ftw_q !== 16'd0) begin
      miscompares++;
      $display("FAIL async_ftw got %0d expected 0", dut.ftw_q);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count(0);
    test_count(1000);
    test_handshake();
    test_sweep_clamp();
    test_sweep_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dds_phase_accumulator.md
# dds_phase_accumulator

Phase-generation stage of the direct digital synthesizer. It sits directly upstream of the phase-to-amplitude converter. It accumulates a frequency tuning word (FTW) every clock and adds a programmable phase offset. It drives the converter's 10-bit `phase` input. Also provides FTW load handshaking, a linear frequency-sweep mode, and a per-cycle wrap pulse for downstream framing.

## Interface
- `ACC_WIDTH`, 16: accumulator/FTW width in bits; legal range 10..32.
- `PHASE_WIDTH`, 10: output phase width; fixed at 10 to match the converter.
- `clk`  input  1  system clock; all state on rising edge.
- `reset_n`  input  1  reset, asynchronous assert, active-low. One clock, asynchronous active-low reset.
- `enable`  input  1  level; 1 = accumulate, 0 = hold accumulator cleared.
- `ftw_in`  input  ACC_WIDTH  new tuning word.
- `phase_off_in`  input  10  phase offset, loaded together with `ftw_in`.
- `ftw_valid`  input  1  `ftw_in`/`phase_off_in` valid.
- `ftw_ready`  output  1  block can accept a load.
- `sweep_start`  input  1  single-cycle pulse; starts sweep from current FTW.
- `sweep_step`  input  ACC_WIDTH  FTW increment per output cycle; sampled every wrap during sweep.
- `sweep_stop`  input  ACC_WIDTH  final FTW of sweep; sampled every wrap during sweep.
- `sweep_done`  output  1  one-cycle pulse when sweep reaches `sweep_stop`.
- `cycle_tick`  output  1  one-cycle pulse aligned with first post-wrap `phase` sample.
- `phase`  output  10  registered phase to converter.

## Operation
- Internal registers are `acc` (ACC_WIDTH), `ftw` (ACC_WIDTH), `poff` (10), and `state` ∈ {IDLE, RUN, SWEEP}.
- Reset values: `acc`=0, `ftw`=0, `poff`=0, `state`=IDLE, `phase`=0, `cycle_tick`=0, `sweep_done`=0, `ftw_ready`=1.
- `ftw_ready` = (state != SWEEP); it is derived from registered state only.
- Load: on an edge with `ftw_valid && ftw_ready`, `ftw`<=`ftw_in` and `poff`<=`phase_off_in`. Loads are accepted in IDLE and RUN.
- IDLE:
  - `acc` held at 0.
  - `enable`=1 -> RUN.
  - `sweep_start` is ignored.
- RUN:
  - `acc` <= `acc` + `ftw`, modulo 2^ACC_WIDTH.
  - `enable`=0 -> IDLE with `acc`<=0 on the same edge.
  - `sweep_start`=1 with `enable`=1 -> SWEEP.
  - If a load and `sweep_start` occur on the same edge, the load takes effect and the sweep begins from the newly loaded FTW.
- SWEEP:
  - Accumulation continues as in RUN.
  - On each edge where the accumulator add carries out (wrap), compute `nxt` = `ftw` + `sweep_step` in ACC_WIDTH+1 bits.
  - If `nxt` >= `sweep_stop`: `ftw`<=`sweep_stop`, pulse `sweep_done`, go to RUN.
  - Otherwise `ftw`<=`nxt`[ACC_WIDTH-1:0].
  - A wrap uses the old `ftw` for the add; the new `ftw` applies from the next edge.
  - If `ftw` >= `sweep_stop` already at start, the first wrap clamps `ftw` to `sweep_stop` and ends the sweep.
  - `enable`=0 -> IDLE: sweep aborted, no `sweep_done`, `ftw` keeps its current value.
- Output: `phase` <= `acc`[ACC_WIDTH-1 -: 10] + `poff`, modulo 1024. In IDLE, `phase` = `poff`.
- `cycle_tick` is the wrap carry, delayed one register so it coincides with the `phase` sample that contains the wrapped `acc`.
- Asserting `reset_n`=0 at any time, including mid-sweep or mid-load, immediately returns every register to its reset value.

## Timing
- FTW load latency: accepted at edge k; first add with the new `ftw` at edge k+1; visible on `phase` after edge k+2.
- `phase` lags `acc` by one cycle. `cycle_tick` and `sweep_done` are each high for exactly one cycle.
- `sweep_done` is asserted the cycle after the clamping edge. `ftw_ready` returns to 1 in that same cycle.
- Leaving IDLE: `acc`=0 at the RUN entry edge; first nonzero `acc` one edge later.
- `sweep_start` pulses while in SWEEP are ignored. `ftw_valid` in SWEEP is held off by `ftw_ready`=0, and the upstream source keeps the data stable.

## Test plan
- **Reset and basic count.** Reset, load `ftw`=64, `poff`=0, `enable`=1.
  - `phase` sequence 0,0,1,2,3… incrementing once per clock.
  - `cycle_tick` every 1024 cycles, coincident with `phase`=0.
- **Phase offset and wrap.** `ftw`=64, `poff`=1000.
  - `phase` 1000…1023,0,1… (modulo 1024).
  - `cycle_tick` when `phase`=1000 after the wrap.
- **Handshake latency.** In RUN with `ftw`=64, load `ftw`=128 at edge k.
  - `ftw_ready`=1 throughout.
  - `phase` step size becomes 2 after edge k+2.
- **Sweep with clamp.** `ftw`=64, `sweep_step`=64, `sweep_stop`=200, pulse `sweep_start`.
  - `ftw_ready`=0.
  - `ftw` goes 128, then 192, then clamps to 200 on the third wrap.
  - `sweep_done` single pulse; `ftw_ready`=1 again.
- **Sweep abort.** Start the same sweep, drop `enable` after the first wrap.
  - State IDLE, `ftw`=128, `phase`=`poff`, no `sweep_done`.
- **Async reset mid-sweep.** Assert `reset_n`=0 between clock edges.
  - All outputs at reset values immediately: `phase`=0, `ftw_ready`=1, pulses low.
